// File: rtl/ureg_pkg.sv
// rtl/ureg_pkg.sv - shared mode encodings for the universal shift register
// Purpose : operating-mode type and constants used by univ_shift_reg and its bench.
// Contents: ureg_mode_t, MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
package ureg_pkg;

  typedef logic [1:0] ureg_mode_t;

  localparam ureg_mode_t MODE_HOLD = 2'b00;
  localparam ureg_mode_t MODE_SHR  = 2'b01;
  localparam ureg_mode_t MODE_SHL  = 2'b10;
  localparam ureg_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/univ_shift_reg_dff_cell.sv
// rtl/univ_shift_reg_dff_cell.sv - single-bit storage cell with true/complement outputs
// Purpose : one edge-triggered bit with asynchronous active-high reset to a per-bit value.
// Ports   : CLK      in  clock, rising edge
//           RST      in  asynchronous active-high reset
//           RST_BIT  in  value loaded while RST=1
//           D        in  next-state bit
//           Q        out stored bit
//           Q_bar    out ~Q, combinational
module dff_cell (
  input  logic CLK,
  input  logic RST,
  input  logic RST_BIT,
  input  logic D,
  output logic Q,
  output logic Q_bar
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q <= RST_BIT;
    end else begin
      Q <= D;
    end
  end

  assign Q_bar = ~Q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - WIDTH-bit universal register: hold, shift right/left, load
// Purpose : storage/serialiser stage built from WIDTH dff_cell instances, each fed by
//           a per-bit 4:1 next-state mux.
// Macro   : UREG_ROTATE_EN adds port ROT; ROT=1 turns both shifts into rotates.
// Params  : WIDTH (2..64), RST_VAL (value of Q during reset)
// Ports   : CLK   in   clock, rising edge
//           RST   in   asynchronous active-high reset
//           EN    in   clock enable, 0 holds regardless of MODE
//           MODE  in   00 hold, 01 shift right, 10 shift left, 11 load
//           D     in   parallel load data
//           SI_R  in   serial input entering at MSB on shift right
//           SI_L  in   serial input entering at LSB on shift left
//           ROT   in   rotate select (UREG_ROTATE_EN only)
//           Q     out  register contents
//           Q_bar out  ~Q
//           SO_R  out  Q[0]
//           SO_L  out  Q[WIDTH-1]
module univ_shift_reg
  import ureg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_R,
  input  logic             SI_L,
`ifdef UREG_ROTATE_EN
  input  logic             ROT,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             SO_R,
  output logic             SO_L
);

  logic             shr_in;
  logic             shl_in;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;

  // Rotation simply feeds the bit leaving one end back into the other end.
`ifdef UREG_ROTATE_EN
  assign shr_in = ROT ? Q[0]       : SI_R;
  assign shl_in = ROT ? Q[WIDTH-1] : SI_L;
`else
  assign shr_in = SI_R;
  assign shl_in = SI_L;
`endif

  assign shr_vec = {shr_in, Q[WIDTH-1:1]};
  assign shl_vec = {Q[WIDTH-2:0], shl_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic nxt_bit;

    // An unknown MODE while enabled propagates X rather than picking a mode.
    always_comb begin
      nxt_bit = Q[i];
      if (EN) begin
        case (MODE)
          MODE_HOLD: nxt_bit = Q[i];
          MODE_SHR:  nxt_bit = shr_vec[i];
          MODE_SHL:  nxt_bit = shl_vec[i];
          MODE_LOAD: nxt_bit = D[i];
          default:   nxt_bit = 1'bx;
        endcase
      end
    end

    dff_cell u_cell (
      .CLK     (CLK),
      .RST     (RST),
      .RST_BIT (RST_VAL[i]),
      .D       (nxt_bit),
      .Q       (Q[i]),
      .Q_bar   (Q_bar[i])
    );
  end

  assign SO_R = Q[0];
  assign SO_L = Q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0)
module tb_univ_shift_reg;
  import ureg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = MODE_HOLD;
  logic [7:0] d = 8'h00;
  logic       si_r = 1'b0;
  logic       si_l = 1'b0;
`ifdef UREG_ROTATE_EN
  logic       rot = 1'b0;
`endif
  logic [7:0] q;
  logic [7:0] q_bar;
  logic       so_r;
  logic       so_l;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .CLK   (clk),
    .RST   (rst),
    .EN    (en),
    .MODE  (mode),
    .D     (d),
    .SI_R  (si_r),
    .SI_L  (si_l),
`ifdef UREG_ROTATE_EN
    .ROT   (rot),
`endif
    .Q     (q),
    .Q_bar (q_bar),
    .SO_R  (so_r),
    .SO_L  (so_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    ureg_mode_t mode;
    logic [7:0] d;
    logic       si_r;
    logic       si_l;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [7:0] exp);
    chk({name, " q"}, {56'd0, q}, {56'd0, exp});
    chk({name, " q_bar"}, {56'd0, q_bar}, {56'd0, ~exp});
    chk({name, " so_r"}, {63'd0, so_r}, {63'd0, exp[0]});
    chk({name, " so_l"}, {63'd0, so_l}, {63'd0, exp[7]});
  endtask

  // Advance to the next rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input ureg_mode_t m, input logic [7:0] dv,
                       input logic sr, input logic sl);
    en = e; mode = m; d = dv; si_r = sr; si_l = sl;
  endtask

  // Reference model: register as an integer, shifts as arithmetic.
  function automatic int model_next(input int cur, input logic e, input ureg_mode_t m,
                                    input logic [7:0] dv, input logic sr, input logic sl,
                                    input logic r);
    int in_bit;
    if (!e) return cur;
    case (m)
      MODE_SHR: begin
        in_bit = r ? (cur % 2) : int'(sr);
        return (cur / 2) + in_bit * 128;
      end
      MODE_SHL: begin
        in_bit = r ? (cur / 128) : int'(sl);
        return ((cur * 2) % 256) + in_bit;
      end
      MODE_LOAD: return int'(dv);
      default:   return cur;
    endcase
  endfunction

  initial begin
    int m;
    logic r;
    logic [7:0] sl_pat;

    // Reset state
    step();
    chk_state("reset", 8'h00);
    step();
    chk_state("reset hold", 8'h00);
    rst = 1'b0;

    // Table: load/hold/enable, shift right from 81, shift-left serial-in to B2.
    vt.push_back('{1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C});
    for (int i = 0; i < 4; i++) vt.push_back('{1'b1, MODE_HOLD, 8'hFF, 1'b0, 1'b0, 8'h3C});
    for (int i = 0; i < 2; i++) vt.push_back('{1'b0, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 8'h3C});
    vt.push_back('{1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81});
    vt.push_back('{1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h40});
    vt.push_back('{1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h20});
    vt.push_back('{1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h10});
    vt.push_back('{1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h08});
    vt.push_back('{1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h04});
    vt.push_back('{1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h02});
    vt.push_back('{1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h01});
    vt.push_back('{1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h00});
    vt.push_back('{1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1, 8'h01});
    vt.push_back('{1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, 8'h02});
    vt.push_back('{1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1, 8'h05});
    vt.push_back('{1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1, 8'h0B});
    vt.push_back('{1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, 8'h16});
    vt.push_back('{1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, 8'h2C});
    vt.push_back('{1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1, 8'h59});
    vt.push_back('{1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0, 8'hB2});
    vt.push_back('{1'b1, MODE_LOAD, 8'hA5, 1'b1, 1'b1, 8'hA5});

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].en, vt[i].mode, vt[i].d, vt[i].si_r, vt[i].si_l);
      step();
      chk_state($sformatf("vec%0d", i), vt[i].exp_q);
    end

    // Async reset between edges, held for 3 edges against a pending load.
    #2;
    drive(1'b1, MODE_LOAD, 8'hFF, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk_state("async reset", 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("reset held %0d", i), 8'h00);
    end
    rst = 1'b0;
    step();
    chk_state("first edge after release", 8'hFF);

    // Mid-operation reset discards a partial shift.
    drive(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk_state("3 shr from FF", 8'h1F);
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk_state("mid-op reset", 8'h00);
    si_r = 1'b1;
    step();
    chk_state("shr after reset", 8'h80);

`ifdef UREG_ROTATE_EN
    drive(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    step();
    rot = 1'b1;
    drive(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
    step();
    chk_state("rotr 1", 8'hC0);
    step();
    chk_state("rotr 2", 8'h60);
    drive(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
    step();
    chk_state("rot load ignores rot", 8'h81);
    drive(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    step();
    chk_state("rotl 1", 8'h03);
    for (int i = 0; i < 7; i++) step();
    chk_state("rotl 8 returns", 8'h81);
    rot = 1'b0;
`endif

    // Randomised run against the integer model.
    m = int'(q);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m = 0;
        chk_state($sformatf("rand reset %0d", i), 8'(m));
      end
      drive(1'($urandom_range(0, 7) != 0), ureg_mode_t'($urandom_range(0, 3)),
            8'($urandom), 1'($urandom), 1'($urandom));
`ifdef UREG_ROTATE_EN
      rot = 1'($urandom);
      r = rot;
`else
      r = 1'b0;
`endif
      m = model_next(m, en, ureg_mode_t'(mode), d, si_r, si_l, r);
      step();
      chk_state($sformatf("rand %0d", i), 8'(m));
    end

    // Shift a random byte fully out to the left and confirm every exiting bit.
    sl_pat = 8'($urandom);
    drive(1'b1, MODE_LOAD, sl_pat, 1'b0, 1'b0);
    step();
    drive(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      chk($sformatf("so_l out %0d", i), {63'd0, so_l}, {63'd0, sl_pat[i]});
      step();
    end
    chk_state("fully shifted out", 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
